hazard_md_ctrl: RTL and testbench
=================================

// Module: hazard_md_ctrl
// PURPOSE
// - Parametrised hazard/forwarding unit for the 5-stage pipeline: ID-stage stall, bypass selects for ID/EX/MEM.
// - Adds a multi-cycle mult/div busy tracker; HI/LO-dependent instructions stall in ID while the MD unit runs.
// - Sits beside the pipeline registers; consumes pre-decoded register/timing fields per stage, drives stall and mux selects.
// PARAMETERS
// - REG_AW      5   register index width; index 0 is the hardwired zero register
// - T_W         2   width of all T_use/T_new fields
// - MULT_CYCLES 5   busy cycles after a mult enters EX (>=1)
// - DIV_CYCLES  10  busy cycles after a div enters EX (>=MULT_CYCLES)
// PORTS
// - clk          in   1       clock
// - reset        in   1       synchronous reset, active-high
// - id_rs/id_rt  in   REG_AW  source regs of instr in ID (0 = unused)
// - id_tuse_rs/id_tuse_rt in T_W  cycles until ID instr needs rs/rt
// - id_is_md     in   1       ID instr is mult/div/mfhi/mflo/mthi/mtlo
// - ex_rs/ex_rt  in   REG_AW  source regs of instr in EX
// - ex_rd        in   REG_AW  dest reg of instr in EX (0 = none)
// - ex_tnew      in   T_W     raw T_new of EX instr, counted from ID
// - ex_md_start  in   1       EX instr is mult/multu/div/divu
// - ex_md_is_div in   1       qualifies ex_md_start: 1 = div
// - mem_rt       in   REG_AW  store-data reg of instr in MEM
// - mem_rd       in   REG_AW  dest reg of instr in MEM
// - mem_tnew     in   T_W     raw T_new of MEM instr
// - wb_rd        in   REG_AW  dest reg of instr in WB
// - stall        out  1       freeze PC and IF/ID, bubble into ID/EX
// - fwd_rs_id/fwd_rt_id out 1 1 = take MEM result in ID
// - fwd_rs_ex/fwd_rt_ex out 2 0 = regfile/pipe, 1 = MEM, 2 = WB
// - fwd_rt_mem   out  1       1 = take WB result for MEM store data
// - md_busy      out  1       MD unit computing
// BEHAVIOUR
// - Residual T_new: ex_res = sat0(ex_tnew-1); mem_res = sat0(mem_tnew-2); WB residual is always 0.
// - Hazard match: src != 0 && src == dst. Forwarding is combinational from current inputs.
// - Bypass: fwd_*_id = match(MEM) && mem_res==0. fwd_*_ex: MEM (mem_res==0) takes priority over WB, else 0. fwd_rt_mem = match(WB).
// - Data stall (per rs/rt): (match(EX) && ex_res > tuse) || (match(MEM) && mem_res > tuse).
// - MD stall: id_is_md && (md_busy || ex_md_start).
// - stall = data stall || MD stall; combinational, no added latency.
// - MD counter md_cnt, width $clog2(DIV_CYCLES+1), reset 0.
//   - ex_md_start: load DIV_CYCLES or MULT_CYCLES (per ex_md_is_div).
//   - else if md_cnt != 0: decrement.
//   - md_busy = (md_cnt != 0), registered-derived.
// - A start while busy (disallowed by stall, but if driven): counter reloads; last start wins.
// - Bubbled EX slot must present ex_md_start=0; block does not gate it.
// - Reset mid-operation: md_cnt cleared next edge; md_busy=0; stall returns to pure data-hazard value.
// - Reset values: md_busy=0; counters 0; combinational outputs follow inputs, all 0 when all inputs 0.
// CONFIGURATION
// - HAZ_STATS_EN defined: adds out ports stall_cnt[31:0] and md_stall_cnt[31:0].
//   - stall_cnt increments every cycle stall=1; md_stall_cnt increments when the MD-stall term is 1.
//   - Both wrap at 2^32 and reset to 0.
// - HAZ_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - ex_rd=8, ex_tnew=3, id_rs=8, id_tuse_rs=0 -> stall=1; next cycle same instr in MEM (mem_tnew=3) -> stall=1, fwd_rs_id=0.
// - mem_rd=9, mem_tnew=2, id_rt=9, ex_rt=9 -> fwd_rt_id=1, fwd_rt_ex=1, stall=0.
// - mem_rd=wb_rd=10, ex_rs=10, mem_res=0 -> fwd_rs_ex=1 (MEM priority); rd=0 with src=0 -> no stall, no forward.
// - ex_md_start=1, ex_md_is_div=0 for 1 cycle -> md_busy=1 exactly 5 cycles; id_is_md=1 -> stall=1 in start cycle + 5 busy cycles, then stall=0.
// - div start, assert reset at busy cycle 4 -> md_busy=0 next edge, stall=0 with id_is_md=1.
// - HAZ_STATS_EN: 3 data stalls + 10 div stalls -> stall_cnt=13, md_stall_cnt=10; reset -> both 0.

Source files
------------

// File: rtl/hazard_md_if.sv
// hazard_md_if: bundle between the pipeline and the hazard/forwarding unit.
//   master modport: the pipeline. It drives the pre-decoded ID/EX/MEM/WB fields
//                   and reads back stall, the bypass selects and md_busy.
//   slave modport:  hazard_md_ctrl. It consumes the fields and drives the results.
interface hazard_md_if #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
);
    logic [REG_AW-1:0] id_rs, id_rt;
    logic [T_W-1:0]    id_tuse_rs, id_tuse_rt;
    logic              id_is_md;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [T_W-1:0]    ex_tnew;
    logic              ex_md_start, ex_md_is_div;
    logic [REG_AW-1:0] mem_rt, mem_rd;
    logic [T_W-1:0]    mem_tnew;
    logic [REG_AW-1:0] wb_rd;
    logic              stall;
    logic              fwd_rs_id, fwd_rt_id;
    logic [1:0]        fwd_rs_ex, fwd_rt_ex;
    logic              fwd_rt_mem;
    logic              md_busy;

    modport master (
        output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
        output ex_rs, ex_rt, ex_rd, ex_tnew, ex_md_start, ex_md_is_div,
        output mem_rt, mem_rd, mem_tnew, wb_rd,
        input  stall, fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex, fwd_rt_mem, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
        input  ex_rs, ex_rt, ex_rd, ex_tnew, ex_md_start, ex_md_is_div,
        input  mem_rt, mem_rd, mem_tnew, wb_rd,
        output stall, fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex, fwd_rt_mem, md_busy
    );
endinterface

// File: rtl/hazard_md_ctrl.sv
// hazard_md_ctrl: ID-stage stall and ID/EX/MEM bypass selects for the 5-stage
// pipeline, plus a mult/div busy tracker.
//   clk, reset : clock and synchronous active-high reset
//   hz (slave) : per-stage register/timing fields in; stall, fwd_* and md_busy out
//   Optional macro HAZ_STATS_EN adds stall_cnt / md_stall_cnt output ports.
// hazard_md_src: per-source-operand hazard check, with one instance for rs and one for rt.

module hazard_md_src #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
) (
    input  logic [REG_AW-1:0] id_src,
    input  logic [T_W-1:0]    tuse,
    input  logic [REG_AW-1:0] ex_src,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [T_W-1:0]    ex_res,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [T_W-1:0]    mem_res,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              fwd_id,
    output logic [1:0]        fwd_ex,
    output logic              data_stall
);
    logic id_hit_ex, id_hit_mem, ex_hit_mem, ex_hit_wb;

    always_comb begin
        // Register 0 never carries a dependency.
        id_hit_ex  = (id_src != '0) && (id_src == ex_rd);
        id_hit_mem = (id_src != '0) && (id_src == mem_rd);
        ex_hit_mem = (ex_src != '0) && (ex_src == mem_rd);
        ex_hit_wb  = (ex_src != '0) && (ex_src == wb_rd);

        fwd_id     = id_hit_mem && (mem_res == '0);
        data_stall = (id_hit_ex && (ex_res > tuse)) || (id_hit_mem && (mem_res > tuse));

        // The younger MEM result wins over WB when it is ready.
        if (ex_hit_mem && (mem_res == '0)) fwd_ex = 2'd1;
        else if (ex_hit_wb)                fwd_ex = 2'd2;
        else                               fwd_ex = 2'd0;
    end
endmodule

module hazard_md_ctrl #(
    parameter int REG_AW      = 5,
    parameter int T_W         = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef HAZ_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt,
`endif
    hazard_md_if.slave  hz
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [T_W-1:0] ex_res, mem_res;
    logic [1:0][REG_AW-1:0] id_src, ex_src;
    logic [1:0][T_W-1:0]    tuse;
    logic [1:0]             fwd_id, data_stall;
    logic [1:0][1:0]        fwd_ex;
    logic [CNT_W-1:0]       md_cnt_q, md_cnt_d;
    logic                   md_busy, md_stall;

    // Residual T_new: the EX value is one cycle on from ID and the MEM value is two. Both saturate at 0.
    assign ex_res  = (hz.ex_tnew == '0) ? '0 : hz.ex_tnew - T_W'(1);
    assign mem_res = (hz.mem_tnew > T_W'(2)) ? hz.mem_tnew - T_W'(2) : '0;

    // Lane 0 is rs and lane 1 is rt.
    assign id_src = {hz.id_rt, hz.id_rs};
    assign ex_src = {hz.ex_rt, hz.ex_rs};
    assign tuse   = {hz.id_tuse_rt, hz.id_tuse_rs};

    for (genvar g = 0; g < 2; g++) begin : g_src
        hazard_md_src #(.REG_AW(REG_AW), .T_W(T_W)) u_src (
            .id_src     (id_src[g]),
            .tuse       (tuse[g]),
            .ex_src     (ex_src[g]),
            .ex_rd      (hz.ex_rd),
            .ex_res     (ex_res),
            .mem_rd     (hz.mem_rd),
            .mem_res    (mem_res),
            .wb_rd      (hz.wb_rd),
            .fwd_id     (fwd_id[g]),
            .fwd_ex     (fwd_ex[g]),
            .data_stall (data_stall[g])
        );
    end

    // A new start reloads the counter even while busy, so the last start wins.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (hz.ex_md_start)
            md_cnt_d = hz.ex_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) md_cnt_q <= '0;
        else       md_cnt_q <= md_cnt_d;
    end

    assign md_busy  = (md_cnt_q != '0);
    // A start in EX blocks an HI/LO user in ID during that same cycle, before the counter loads.
    assign md_stall = hz.id_is_md && (md_busy || hz.ex_md_start);

    assign hz.stall      = |data_stall || md_stall;
    assign hz.fwd_rs_id  = fwd_id[0];
    assign hz.fwd_rt_id  = fwd_id[1];
    assign hz.fwd_rs_ex  = fwd_ex[0];
    assign hz.fwd_rt_ex  = fwd_ex[1];
    assign hz.fwd_rt_mem = (hz.mem_rt != '0) && (hz.mem_rt == hz.wb_rd);
    assign hz.md_busy    = md_busy;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, md_stall_cnt_q, md_stall_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q + {31'd0, hz.stall};
        md_stall_cnt_d = md_stall_cnt_q + {31'd0, md_stall};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_md_ctrl.sv
// tb_hazard_md_ctrl: directed and random checks of hazard_md_ctrl against a behavioural
// model. The model tracks the MD unit as "the last start cycle plus its length".
module tb_hazard_md_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_md_if #(.REG_AW(5), .T_W(2)) bus ();
`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt, md_stall_cnt;
`endif

    hazard_md_ctrl #(.REG_AW(5), .T_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef HAZ_STATS_EN
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt),
`endif
        .hz           (bus)
    );

    int cmps = 0, fails = 0;
    int cyc = 0;
    int ms_start = -1000, ms_len = 0;   // cycle of the last accepted MD start and its busy length
    int m_stall_cnt = 0, m_md_stall_cnt = 0;
    int e_stall, e_mds;                 // this cycle's expected stall and MD-stall term

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit hit(int s, int d);
        return (s != 0) && (s == d);
    endfunction

    function automatic int fex(int s, int mem_rd, int mr, int wb_rd);
        if (hit(s, mem_rd) && mr == 0) return 1;
        if (hit(s, wb_rd)) return 2;
        return 0;
    endfunction

    task automatic clr();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_tuse_rs = '0; bus.id_tuse_rt = '0;
        bus.id_is_md = 1'b0; bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_rd = '0;
        bus.ex_tnew = '0; bus.ex_md_start = 1'b0; bus.ex_md_is_div = 1'b0;
        bus.mem_rt = '0; bus.mem_rd = '0; bus.mem_tnew = '0; bus.wb_rd = '0;
    endtask

    // Wait for the falling edge, then compare every output with the model.
    task automatic sample(string tag);
        int er, mr, ds_rs, ds_rt, busy;
        @(negedge clk);
        er = (int'(bus.ex_tnew) > 1) ? int'(bus.ex_tnew) - 1 : 0;
        mr = (int'(bus.mem_tnew) > 2) ? int'(bus.mem_tnew) - 2 : 0;
        busy  = (cyc > ms_start && cyc <= ms_start + ms_len) ? 1 : 0;
        ds_rs = ((hit(bus.id_rs, bus.ex_rd) && er > int'(bus.id_tuse_rs)) ||
                 (hit(bus.id_rs, bus.mem_rd) && mr > int'(bus.id_tuse_rs))) ? 1 : 0;
        ds_rt = ((hit(bus.id_rt, bus.ex_rd) && er > int'(bus.id_tuse_rt)) ||
                 (hit(bus.id_rt, bus.mem_rd) && mr > int'(bus.id_tuse_rt))) ? 1 : 0;
        e_mds   = (bus.id_is_md && (busy == 1 || bus.ex_md_start)) ? 1 : 0;
        e_stall = (ds_rs == 1 || ds_rt == 1 || e_mds == 1) ? 1 : 0;
        chk({tag, ".md_busy"},    32'(bus.md_busy), busy);
        chk({tag, ".stall"},      32'(bus.stall), e_stall);
        chk({tag, ".fwd_rs_id"},  32'(bus.fwd_rs_id), (hit(bus.id_rs, bus.mem_rd) && mr == 0) ? 1 : 0);
        chk({tag, ".fwd_rt_id"},  32'(bus.fwd_rt_id), (hit(bus.id_rt, bus.mem_rd) && mr == 0) ? 1 : 0);
        chk({tag, ".fwd_rs_ex"},  32'(bus.fwd_rs_ex), fex(bus.ex_rs, bus.mem_rd, mr, bus.wb_rd));
        chk({tag, ".fwd_rt_ex"},  32'(bus.fwd_rt_ex), fex(bus.ex_rt, bus.mem_rd, mr, bus.wb_rd));
        chk({tag, ".fwd_rt_mem"}, 32'(bus.fwd_rt_mem), hit(bus.mem_rt, bus.wb_rd) ? 1 : 0);
`ifdef HAZ_STATS_EN
        chk({tag, ".stall_cnt"},    stall_cnt, m_stall_cnt);
        chk({tag, ".md_stall_cnt"}, md_stall_cnt, m_md_stall_cnt);
`endif
    endtask

    // Rising edge: advance the model using this cycle's inputs.
    task automatic adv();
        @(posedge clk);
        if (reset) begin
            ms_start = -1000; m_stall_cnt = 0; m_md_stall_cnt = 0;
        end else begin
            if (bus.ex_md_start) begin
                ms_start = cyc; ms_len = bus.ex_md_is_div ? 10 : 5;
            end
            m_stall_cnt += e_stall; m_md_stall_cnt += e_mds;
        end
        cyc++;
        #1;
    endtask

    initial begin
        int nbusy, nstall;
        clr(); reset = 1'b1;
        // Reset with all inputs at zero: every output must read 0.
        sample("reset0"); adv();
        sample("reset1"); adv();
        reset = 1'b0;

        // EX producer with residual 2 against tuse 0 stalls. One cycle later in MEM the residual is 1, so still a stall and no ID forward.
        bus.ex_rd = 5'd8; bus.ex_tnew = 2'd3; bus.id_rs = 5'd8;
        sample("ex_stall"); chk("ex_stall.direct", 32'(bus.stall), 1); adv();
        bus.ex_rd = '0; bus.ex_tnew = '0; bus.mem_rd = 5'd8; bus.mem_tnew = 2'd3;
        sample("mem_stall");
        chk("mem_stall.direct", 32'(bus.stall), 1);
        chk("mem_stall.fwd", 32'(bus.fwd_rs_id), 0); adv();

        // MEM result ready: forward to ID and EX rt with no stall.
        clr(); bus.mem_rd = 5'd9; bus.mem_tnew = 2'd2; bus.id_rt = 5'd9; bus.ex_rt = 5'd9;
        sample("mem_fwd");
        chk("mem_fwd.id", 32'(bus.fwd_rt_id), 1);
        chk("mem_fwd.ex", 32'(bus.fwd_rt_ex), 1);
        chk("mem_fwd.stall", 32'(bus.stall), 0); adv();

        // MEM wins over WB. Register 0 never matches.
        clr(); bus.mem_rd = 5'd10; bus.wb_rd = 5'd10; bus.ex_rs = 5'd10;
        sample("prio"); chk("prio.direct", 32'(bus.fwd_rs_ex), 1); adv();
        clr(); bus.ex_tnew = 2'd3; bus.mem_tnew = 2'd3;
        sample("zero_reg");
        chk("zero_reg.stall", 32'(bus.stall), 0);
        chk("zero_reg.fwd", 32'(bus.fwd_rs_ex), 0); adv();

        // Mult for one cycle with id_is_md held: expect 5 busy cycles and 6 stall cycles.
        clr(); bus.id_is_md = 1'b1; bus.ex_md_start = 1'b1;
        nbusy = 0; nstall = 0;
        for (int i = 0; i < 10; i++) begin
            sample("mult");
            nbusy += int'(bus.md_busy); nstall += int'(bus.stall);
            adv();
            bus.ex_md_start = 1'b0;
        end
        chk("mult.busy_cycles", nbusy, 5);
        chk("mult.stall_cycles", nstall, 6);

        // Div start, then reset asserted in the 4th busy cycle.
        clr(); bus.ex_md_start = 1'b1; bus.ex_md_is_div = 1'b1;
        sample("div_start"); adv();
        clr(); bus.id_is_md = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) reset = 1'b1;
            sample("div_busy"); adv();
        end
        reset = 1'b0;
        sample("div_rst");
        chk("div_rst.busy", 32'(bus.md_busy), 0);
        chk("div_rst.stall", 32'(bus.stall), 0); adv();

`ifdef HAZ_STATS_EN
        // Statistics: 10 div stalls followed by 3 data stalls.
        clr(); reset = 1'b1; sample("st_rst"); adv(); reset = 1'b0;
        bus.ex_md_start = 1'b1; bus.ex_md_is_div = 1'b1; sample("st_div"); adv();
        clr(); bus.id_is_md = 1'b1;
        for (int i = 0; i < 10; i++) begin sample("st_md"); adv(); end
        clr(); bus.ex_rd = 5'd8; bus.ex_tnew = 2'd3; bus.id_rs = 5'd8;
        for (int i = 0; i < 3; i++) begin sample("st_data"); adv(); end
        clr(); sample("st_end");
        chk("stats.stall_cnt", stall_cnt, 13);
        chk("stats.md_stall_cnt", md_stall_cnt, 10); adv();
        reset = 1'b1; sample("st_clr"); adv(); reset = 1'b0;
        sample("st_zero");
        chk("stats.zero_stall", stall_cnt, 0);
        chk("stats.zero_md", md_stall_cnt, 0); adv();
`endif

        // Random traffic on a small register range so that matches are frequent.
        for (int i = 0; i < 400; i++) begin
            reset            = ($urandom_range(0, 39) == 0);
            bus.id_rs        = 5'($urandom_range(0, 3));
            bus.id_rt        = 5'($urandom_range(0, 3));
            bus.id_tuse_rs   = 2'($urandom_range(0, 3));
            bus.id_tuse_rt   = 2'($urandom_range(0, 3));
            bus.id_is_md     = ($urandom_range(0, 3) == 0);
            bus.ex_rs        = 5'($urandom_range(0, 3));
            bus.ex_rt        = 5'($urandom_range(0, 3));
            bus.ex_rd        = 5'($urandom_range(0, 3));
            bus.ex_tnew      = 2'($urandom_range(0, 3));
            bus.ex_md_start  = ($urandom_range(0, 7) == 0);
            bus.ex_md_is_div = 1'($urandom_range(0, 1));
            bus.mem_rt       = 5'($urandom_range(0, 3));
            bus.mem_rd       = 5'($urandom_range(0, 3));
            bus.mem_tnew     = 2'($urandom_range(0, 3));
            bus.wb_rd        = 5'($urandom_range(0, 3));
            sample("rand"); adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end
endmodule
